// File: rtl/param_updown_counter.sv
// Up/down counter with its own prescaler, synchronous clear/load (load clamped into range), wrap or saturate at the ends.
// count steps on the edge ending a tick cycle; wrap is a registered pulse one cycle later; no backpressure, en gates progress.
module param_updown_counter #(
  parameter int WIDTH     = 4,
  parameter int MODULUS   = 16,
  parameter int PRESCALE  = 1,
  parameter int SATURATE  = 0,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tick,
  output logic             tc,
  output logic             wrap
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_VAL);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);
  localparam logic [PS_W-1:0]  PS_LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0]  ps;
  logic             ps_done;
  logic [WIDTH-1:0] step_val;
  logic [WIDTH-1:0] load_clamped;

  assign ps_done      = (ps == PS_LAST);
  assign tick         = en & ps_done & ~clear & ~load;
  assign tc           = up ? (count == MAX_VAL) : (count == '0);
  // Extra MSB so MODULUS == 2**WIDTH compares correctly.
  assign load_clamped = ({1'b0, load_val} < MOD_EXT) ? load_val : MAX_VAL;

  always_comb begin
    step_val = count;
    if (!tc) begin
      step_val = up ? count + WIDTH'(1) : count - WIDTH'(1);
    end else if (SATURATE == 0) begin
      step_val = up ? '0 : MAX_VAL;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= RST_VAL;
      ps    <= '0;
      wrap  <= 1'b0;
    end else if (clear) begin
      count <= RST_VAL;
      ps    <= '0;
      wrap  <= 1'b0;
    end else if (load) begin
      count <= load_clamped;
      ps    <= '0;
      wrap  <= 1'b0;
    end else begin
      if (en) begin
        ps <= ps_done ? '0 : ps + PS_W'(1);
      end
      if (tick) begin
        count <= step_val;
      end
      wrap <= tick & tc;
    end
  end

  initial begin
    if (WIDTH < 1) $error("param_updown_counter: WIDTH must be >= 1");
    if (MODULUS < 2 || MODULUS > (1 << WIDTH))
      $error("param_updown_counter: MODULUS must be in 2..2**WIDTH");
    if (PRESCALE < 1) $error("param_updown_counter: PRESCALE must be >= 1");
    if (SATURATE != 0 && SATURATE != 1) $error("param_updown_counter: SATURATE must be 0 or 1");
    if (RESET_VAL < 0 || RESET_VAL >= MODULUS)
      $error("param_updown_counter: RESET_VAL must be < MODULUS");
  end

endmodule

// File: tb/tb_param_updown_counter.sv
// Directed bench: three counter configurations driven in sequence from one initial block.
module tb_param_updown_counter;

  logic       clk;
  logic       reset;
  logic       en_a, up_a, clear_a, load_a, tick_a, tc_a, wrap_a;
  logic [3:0] load_val_a, count_a;
  logic       en_b, up_b, clear_b, load_b, tick_b, tc_b, wrap_b;
  logic [3:0] load_val_b, count_b;
  logic       en_c, up_c, clear_c, load_c, tick_c, tc_c, wrap_c;
  logic [3:0] load_val_c, count_c;

  int n_pass = 0;
  int n_fail = 0;
  int n_chk  = 0;

  // a: 4-bit mod-16, no prescale, wrap
  param_updown_counter #(.WIDTH(4), .MODULUS(16), .PRESCALE(1), .SATURATE(0), .RESET_VAL(0)) dut_a (
    .clk(clk), .reset(reset), .en(en_a), .up(up_a), .clear(clear_a), .load(load_a),
    .load_val(load_val_a), .count(count_a), .tick(tick_a), .tc(tc_a), .wrap(wrap_a));

  // b: mod-10, no prescale, wrap
  param_updown_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(1), .SATURATE(0), .RESET_VAL(0)) dut_b (
    .clk(clk), .reset(reset), .en(en_b), .up(up_b), .clear(clear_b), .load(load_b),
    .load_val(load_val_b), .count(count_b), .tick(tick_b), .tc(tc_b), .wrap(wrap_b));

  // c: mod-10, prescale 4, saturate, reset value 2
  param_updown_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(4), .SATURATE(1), .RESET_VAL(2)) dut_c (
    .clk(clk), .reset(reset), .en(en_c), .up(up_c), .clear(clear_c), .load(load_c),
    .load_val(load_val_c), .count(count_c), .tick(tick_c), .tc(tc_c), .wrap(wrap_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk = n_chk + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else begin
      n_fail = n_fail + 1;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish (%0d/%0d passed so far)", n_pass, n_chk);
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    en_a = 1'b0; up_a = 1'b0; clear_a = 1'b0; load_a = 1'b0; load_val_a = 4'd0;
    en_b = 1'b0; up_b = 1'b1; clear_b = 1'b0; load_b = 1'b0; load_val_b = 4'd0;
    en_c = 1'b0; up_c = 1'b1; clear_c = 1'b0; load_c = 1'b0; load_val_c = 4'd0;
    cyc();
    cyc();
    chk("rst_count_a", count_a, 0);
    chk("rst_wrap_a", wrap_a, 0);
    chk("rst_count_b", count_b, 0);
    chk("rst_count_c", count_c, 2);

    // Down-count from reset through 0 -> 15 twice
    reset = 1'b0;
    en_a  = 1'b1;
    up_a  = 1'b0;
    #1;
    chk("t1_tc_at_0", tc_a, 1);
    chk("t1_first_tick", tick_a, 1);
    for (int k = 1; k <= 17; k++) begin
      if (k == 16) en_c = 1'b1;
      cyc();
      chk("t1_count", count_a, (32 - k) % 16);
      chk("t1_wrap", wrap_a, (k == 1 || k == 17));
    end
    chk("t6_c_before_reset", count_c, 2);

    // Async reset between edges while a has wrap high and c is mid-prescale
    #1 reset = 1'b1;
    #1;
    chk("t6_async_count_a", count_a, 0);
    chk("t6_async_wrap_a", wrap_a, 0);
    chk("t6_async_count_c", count_c, 2);
    en_c = 1'b0;
    #2 reset = 1'b0;
    cyc();
    chk("t6_resume_a", count_a, 15);
    en_a = 1'b0;

    // Prescale 4 with an en gap: ps must freeze, step on the 4th enabled cycle
    en_c = 1'b1;
    up_c = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      #1 chk("t3_no_tick", tick_c, 0);
      cyc();
      chk("t3_hold", count_c, 2);
    end
    en_c = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      #1 chk("t3_en_low_tick", tick_c, 0);
      cyc();
      chk("t3_en_low_hold", count_c, 2);
    end
    en_c = 1'b1;
    #1 chk("t3_tick_4th", tick_c, 1);
    cyc();
    chk("t3_step", count_c, 3);

    // Saturate at the top, then reverse and saturate at 0
    load_c = 1'b1;
    load_val_c = 4'd9;
    #1 chk("t4_load_no_tick", tick_c, 0);
    cyc();
    chk("t4_load9", count_c, 9);
    load_c = 1'b0;
    #1 chk("t4_tc_top", tc_c, 1);
    for (int j = 1; j <= 2; j++) begin
      for (int i = 1; i <= 4; i++) begin
        cyc();
        chk("t4_sat_hi", count_c, 9);
        chk("t4_sat_hi_wrap", wrap_c, (i == 4));
      end
    end
    up_c = 1'b0;
    for (int j = 1; j <= 10; j++) begin
      for (int i = 1; i <= 4; i++) begin
        int e;
        cyc();
        e = 9 - j + ((i < 4) ? 1 : 0);
        if (e < 0) e = 0;
        chk("t4_down", count_c, e);
        chk("t4_down_wrap", wrap_c, (i == 4 && j == 10));
      end
    end
    en_c = 1'b0;

    // Mod-10 up count: tc only at 9, wrap one cycle after 9 -> 0
    en_b = 1'b1;
    up_b = 1'b1;
    #1 chk("t2_tc_at_0", tc_b, 0);
    for (int k = 1; k <= 11; k++) begin
      cyc();
      chk("t2_count", count_b, k % 10);
      chk("t2_tc", tc_b, ((k % 10) == 9));
      chk("t2_wrap", wrap_b, (k == 10));
    end

    // Load clamp, clear beats load, load beats tick
    load_b = 1'b1;
    load_val_b = 4'd12;
    #1 chk("t5_load_no_tick", tick_b, 0);
    cyc();
    chk("t5_clamp12", count_b, 9);
    chk("t5_load_wrap", wrap_b, 0);
    clear_b = 1'b1;
    load_val_b = 4'd3;
    cyc();
    chk("t5_clear_wins", count_b, 0);
    clear_b = 1'b0;
    load_val_b = 4'd7;
    cyc();
    chk("t5_load_over_tick", count_b, 7);
    load_val_b = 4'd10;
    cyc();
    chk("t5_clamp10", count_b, 9);
    load_b = 1'b0;
    #1;
    chk("t5_tc_9", tc_b, 1);
    chk("t5_tick_9", tick_b, 1);
    cyc();
    chk("t5_wrap_to_0", count_b, 0);
    chk("t5_wrap_pulse", wrap_b, 1);
    en_b = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
